alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID/EX pipeline stage directly upstream of the core ALU. Captures decoded
//  instructions and resolves operands: register-file value, EX/MEM forward or
//  MEM/WB forward. Selects the PC/immediate operands and detects load-use
//  hazards. Presents a registered {op, a, b} to the combinational ALU under a
//  valid/ready handshake.
// PARAMETERS
//  Width     32  datapath width of operands, PC and immediate
//  RegAddrW  5   register index width; index 0 is hardwired zero
// PORTS
//  clk_i           in   1         clock, rising edge
//  rst_i           in   1         synchronous reset, active-high
//  flush_i         in   1         kill held and incoming instruction (branch/trap)
//  in_valid_i      in   1         decoded instruction present
//  in_ready_o      out  1         stage accepts instruction this cycle
//  in_op_i         in   4         ALU op code, passed through unchanged
//  in_rs1_i        in   RegAddrW  source register 1 index
//  in_rs2_i        in   RegAddrW  source register 2 index
//  in_rs1_data_i   in   Width     register-file read data, rs1
//  in_rs2_data_i   in   Width     register-file read data, rs2
//  in_pc_i         in   Width     instruction PC
//  in_imm_i        in   Width     sign-extended immediate
//  in_a_sel_i      in   2         0=rs1, 1=PC, 2=zero, 3=reserved (treated as zero)
//  in_b_sel_i      in   1         0=rs2, 1=imm
//  in_rd_i         in   RegAddrW  destination index, carried to out_rd_o
//  ex_load_i       in   1         instruction in EX is a load
//  ex_rd_i         in   RegAddrW  EX-stage destination (load-use check only)
//  exm_we_i        in   1         EX/MEM writes a register
//  exm_rd_i        in   RegAddrW  EX/MEM destination
//  exm_data_i      in   Width     EX/MEM result
//  mwb_we_i        in   1         MEM/WB writes a register
//  mwb_rd_i        in   RegAddrW  MEM/WB destination
//  mwb_data_i      in   Width     MEM/WB result
//  out_valid_o     out  1         held instruction valid toward ALU
//  out_ready_i     in   1         EX consumes held instruction
//  op_o            out  4         to ALU op_i
//  a_o             out  Width     to ALU a_i
//  b_o             out  Width     to ALU b_i
//  store_data_o    out  Width     forwarded rs2, for stores
//  out_rd_o        out  RegAddrW  destination index
// BEHAVIOUR
//  - Reset: out_valid_o=0; op_o, a_o, b_o, store_data_o and out_rd_o all 0.
//  - Single-entry register. Latency 1: an instruction accepted in cycle N is
//    presented in cycle N+1.
//  - Transfer in: in_valid_i && in_ready_o. Transfer out: out_valid_o && out_ready_i.
//  - hazard = ex_load_i && ex_rd_i!=0 && ((ex_rd_i==in_rs1_i && in_a_sel_i==0)
//    || ex_rd_i==in_rs2_i). rs2 is always checked because of store data.
//  - in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i.
//  - Forward value per source s (priority order):
//    exm_we_i && exm_rd_i==s && s!=0 -> exm_data_i;
//    else mwb_we_i && mwb_rd_i==s && s!=0 -> mwb_data_i;
//    else s==0 -> 0; else register-file data.
//    Forwarding is evaluated only at capture. The held operands are not
//    re-forwarded.
//  - a = fwd(rs1), in_pc_i or 0 per in_a_sel_i. b = fwd(rs2) or in_imm_i.
//    store_data_o = fwd(rs2).
//  - Out accepted, no new input (incl. hazard): out_valid_o->0 (bubble).
//    Payload may hold stale value.
//  - Output stalled (out_valid_o && !out_ready_i): all outputs hold stable.
//  - flush_i: out_valid_o->0 next cycle regardless of other inputs. Input is
//    not accepted that cycle.
//  - Reset wins over flush. Reset mid-stall drops the held instruction.
// TESTING
//  1 reset, then rs1=x3 (rf=5), rs2=x4 (rf=7), op=0000 -> next cycle
//    a_o=5, b_o=7, op_o=0000, out_valid_o=1.
//  2 exm_we_i=1, exm_rd_i=3, exm_data_i=0x100 and mwb_we_i=1, mwb_rd_i=3,
//    mwb_data_i=0x200, rs1=x3 -> a_o=0x100.
//  3 rs1=x0 with exm_rd_i=0, exm_we_i=1, exm_data_i=0xDEAD -> a_o=0.
//    a_sel=1, pc=0x80 -> a_o=0x80.
//  4 ex_load_i=1, ex_rd_i=4, in rs2=x4 -> in_ready_o=0 for that cycle.
//    Bubble: out_valid_o=0 after the current output drains. Accepted next
//    cycle once ex_load_i=0.
//  5 out_ready_i=0 for 3 cycles with out_valid_o=1 -> outputs constant and
//    in_ready_o=0. out_ready_i=1 with new input -> back-to-back, no bubble.
//  6 flush_i pulsed while out_valid_o=1 and in_valid_i=1 -> out_valid_o=0
//    next cycle and input not consumed. rst_i mid-stall -> out_valid_o=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// ID/EX pipeline register that sits directly in front of the combinational
// ALU. It captures one decoded instruction, resolves its source operands
// (EX/MEM forward, MEM/WB forward, x0, or register-file data), selects the
// A/B operands (rs1/PC/zero and rs2/imm), and stalls the front end on a
// load-use hazard. The held {op, a, b} drives the ALU directly.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   flush_i               kill the held and the incoming instruction
//   in_valid_i/in_ready_o upstream handshake (decoded instruction)
//   in_op_i .. in_rd_i    decoded instruction fields and register-file data
//   ex_load_i, ex_rd_i    load currently in EX (load-use detection)
//   exm_we_i/rd_i/data_i  EX/MEM writeback, forwarding source (higher priority)
//   mwb_we_i/rd_i/data_i  MEM/WB writeback, forwarding source (lower priority)
//   out_valid_o/ready_i   downstream handshake toward EX
//   op_o, a_o, b_o        registered ALU inputs
//   store_data_o          forwarded rs2, used by stores
//   out_rd_o              destination register index
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready_o depends combinationally on out_ready_i, the hazard check
// and flush_i; out_valid_o and the payload come straight from registers and
// do not change while out_valid_o && !out_ready_i.
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int Width    = 32,
  parameter int RegAddrW = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [3:0]          in_op_i,
  input  logic [RegAddrW-1:0] in_rs1_i,
  input  logic [RegAddrW-1:0] in_rs2_i,
  input  logic [Width-1:0]    in_rs1_data_i,
  input  logic [Width-1:0]    in_rs2_data_i,
  input  logic [Width-1:0]    in_pc_i,
  input  logic [Width-1:0]    in_imm_i,
  input  logic [1:0]          in_a_sel_i,
  input  logic                in_b_sel_i,
  input  logic [RegAddrW-1:0] in_rd_i,
  input  logic                ex_load_i,
  input  logic [RegAddrW-1:0] ex_rd_i,
  input  logic                exm_we_i,
  input  logic [RegAddrW-1:0] exm_rd_i,
  input  logic [Width-1:0]    exm_data_i,
  input  logic                mwb_we_i,
  input  logic [RegAddrW-1:0] mwb_rd_i,
  input  logic [Width-1:0]    mwb_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [3:0]          op_o,
  output logic [Width-1:0]    a_o,
  output logic [Width-1:0]    b_o,
  output logic [Width-1:0]    store_data_o,
  output logic [RegAddrW-1:0] out_rd_o
);

  localparam logic [1:0] ASelRs1 = 2'd0;
  localparam logic [1:0] ASelPc  = 2'd1;

  logic                r_valid;
  logic [3:0]          r_op;
  logic [Width-1:0]    r_a;
  logic [Width-1:0]    r_b;
  logic [Width-1:0]    r_store;
  logic [RegAddrW-1:0] r_rd;

  logic             w_hazard;
  logic             w_accept;
  logic [Width-1:0] w_rs1_fwd;
  logic [Width-1:0] w_rs2_fwd;
  logic [Width-1:0] w_a;
  logic [Width-1:0] w_b;

  // Operand resolution for one source index. EX/MEM is the younger result, so
  // it beats MEM/WB; x0 is never forwarded and always reads as zero.
  function automatic logic [Width-1:0] fwd_sel(
    input logic [RegAddrW-1:0] src,
    input logic [Width-1:0]    rf_data,
    input logic                exm_we,
    input logic [RegAddrW-1:0] exm_rd,
    input logic [Width-1:0]    exm_data,
    input logic                mwb_we,
    input logic [RegAddrW-1:0] mwb_rd,
    input logic [Width-1:0]    mwb_data
  );
    logic [Width-1:0] v;
    if (exm_we && (exm_rd == src) && (src != '0)) begin
      v = exm_data;
    end else if (mwb_we && (mwb_rd == src) && (src != '0)) begin
      v = mwb_data;
    end else if (src == '0) begin
      v = '0;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  // rs1 only matters when the A operand actually uses it; rs2 is always
  // checked because stores need it as store data even when B is the immediate.
  always_comb begin
    w_hazard = 1'b0;
    if (ex_load_i && (ex_rd_i != '0)) begin
      w_hazard = ((ex_rd_i == in_rs1_i) && (in_a_sel_i == ASelRs1)) ||
                 (ex_rd_i == in_rs2_i);
    end
  end

  assign in_ready_o = (!r_valid || out_ready_i) && !w_hazard && !flush_i;
  assign w_accept   = in_valid_i && in_ready_o;

  always_comb begin
    w_rs1_fwd = fwd_sel(in_rs1_i, in_rs1_data_i, exm_we_i, exm_rd_i, exm_data_i,
                        mwb_we_i, mwb_rd_i, mwb_data_i);
    w_rs2_fwd = fwd_sel(in_rs2_i, in_rs2_data_i, exm_we_i, exm_rd_i, exm_data_i,
                        mwb_we_i, mwb_rd_i, mwb_data_i);
  end

  // Selector value 3 is reserved and reads as zero, same as 2.
  always_comb begin
    w_a = '0;
    case (in_a_sel_i)
      ASelRs1: w_a = w_rs1_fwd;
      ASelPc:  w_a = in_pc_i;
      default: w_a = '0;
    endcase
    w_b = in_b_sel_i ? in_imm_i : w_rs2_fwd;
  end

  // Priority: reset, flush, capture, drain. When the output is stalled none of
  // the branches fire, so every register holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_store <= '0;
      r_rd    <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_op    <= in_op_i;
      r_a     <= w_a;
      r_b     <= w_b;
      r_store <= w_rs2_fwd;
      r_rd    <= in_rd_i;
    end else if (out_ready_i) begin
      // Held instruction consumed with nothing new behind it: bubble.
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o  = r_valid;
  assign op_o         = r_op;
  assign a_o          = r_a;
  assign b_o          = r_b;
  assign store_data_o = r_store;
  assign out_rd_o     = r_rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  localparam int W  = 32;
  localparam int RW = 5;
  localparam int PW = 4 + 3 * W + RW;

  logic          clk_i;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [3:0]    in_op_i;
  logic [RW-1:0] in_rs1_i;
  logic [RW-1:0] in_rs2_i;
  logic [W-1:0]  in_rs1_data_i;
  logic [W-1:0]  in_rs2_data_i;
  logic [W-1:0]  in_pc_i;
  logic [W-1:0]  in_imm_i;
  logic [1:0]    in_a_sel_i;
  logic          in_b_sel_i;
  logic [RW-1:0] in_rd_i;
  logic          ex_load_i;
  logic [RW-1:0] ex_rd_i;
  logic          exm_we_i;
  logic [RW-1:0] exm_rd_i;
  logic [W-1:0]  exm_data_i;
  logic          mwb_we_i;
  logic [RW-1:0] mwb_rd_i;
  logic [W-1:0]  mwb_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [3:0]    op_o;
  logic [W-1:0]  a_o;
  logic [W-1:0]  b_o;
  logic [W-1:0]  store_data_o;
  logic [RW-1:0] out_rd_o;

  alu_operand_stage #(.Width(W), .RegAddrW(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_op_i(in_op_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
    .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
    .in_pc_i(in_pc_i), .in_imm_i(in_imm_i),
    .in_a_sel_i(in_a_sel_i), .in_b_sel_i(in_b_sel_i), .in_rd_i(in_rd_i),
    .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
    .exm_we_i(exm_we_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
    .mwb_we_i(mwb_we_i), .mwb_rd_i(mwb_rd_i), .mwb_data_i(mwb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .op_o(op_o), .a_o(a_o), .b_o(b_o),
    .store_data_o(store_data_o), .out_rd_o(out_rd_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- vector table type ----------------
  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [W-1:0]  rs1_data;
    logic [W-1:0]  rs2_data;
    logic [W-1:0]  pc;
    logic [W-1:0]  imm;
    logic [1:0]    a_sel;
    logic          b_sel;
    logic [RW-1:0] rd;
    logic          exm_we;
    logic [RW-1:0] exm_rd;
    logic [W-1:0]  exm_data;
    logic          mwb_we;
    logic [RW-1:0] mwb_rd;
    logic [W-1:0]  mwb_data;
    logic [W-1:0]  exp_a;
    logic [W-1:0]  exp_b;
    logic [W-1:0]  exp_st;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int checks;
  int errors;

  function automatic logic [PW-1:0] cur_pkt();
    return {op_o, a_o, b_o, store_data_o, out_rd_o};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_q.push_back({v.op, v.exp_a, v.exp_b, v.exp_st, v.rd});
  endtask

  task automatic check_out(input string name);
    logic [PW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=output exp=empty_queue", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_valid"}, 128'(out_valid_o), 128'(1'b1));
      check(name, 128'(cur_pkt()), 128'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid_i    = 1'b1;
    in_op_i       = v.op;
    in_rs1_i      = v.rs1;
    in_rs2_i      = v.rs2;
    in_rs1_data_i = v.rs1_data;
    in_rs2_data_i = v.rs2_data;
    in_pc_i       = v.pc;
    in_imm_i      = v.imm;
    in_a_sel_i    = v.a_sel;
    in_b_sel_i    = v.b_sel;
    in_rd_i       = v.rd;
    exm_we_i      = v.exm_we;
    exm_rd_i      = v.exm_rd;
    exm_data_i    = v.exm_data;
    mwb_we_i      = v.mwb_we;
    mwb_rd_i      = v.mwb_rd;
    mwb_data_i    = v.mwb_data;
  endtask

  task automatic drive_idle();
    in_valid_i    = 1'b0;
    in_op_i       = '0;
    in_rs1_i      = '0;
    in_rs2_i      = '0;
    in_rs1_data_i = '0;
    in_rs2_data_i = '0;
    in_pc_i       = '0;
    in_imm_i      = '0;
    in_a_sel_i    = '0;
    in_b_sel_i    = 1'b0;
    in_rd_i       = '0;
    ex_load_i     = 1'b0;
    ex_rd_i       = '0;
    exm_we_i      = 1'b0;
    exm_rd_i      = '0;
    exm_data_i    = '0;
    mwb_we_i      = 1'b0;
    mwb_rd_i      = '0;
    mwb_data_i    = '0;
  endtask

  // ---------------- test ----------------
  vec_t va, vb, vc, vd, ve;

  initial begin
    checks = 0;
    errors = 0;

    //            op     rs1    rs2    rs1_data        rs2_data      pc          imm            as    bs    rd      ew    erd    edata          mw    mrd    mdata          exp_a          exp_b          exp_st
    vecs[0] = '{4'h0, 5'd3, 5'd4, 32'h5,          32'h7,        32'h0,      32'h0,         2'd0, 1'b0, 5'd1,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         32'h5,         32'h7,         32'h7};
    vecs[1] = '{4'h1, 5'd3, 5'd4, 32'h5,          32'h7,        32'h0,      32'h0,         2'd0, 1'b0, 5'd2,  1'b1, 5'd3, 32'h100,       1'b1, 5'd3, 32'h200,       32'h100,       32'h7,         32'h7};
    vecs[2] = '{4'h2, 5'd0, 5'd5, 32'h1234,       32'h9,        32'h0,      32'h0,         2'd0, 1'b0, 5'd3,  1'b1, 5'd0, 32'hDEAD,      1'b0, 5'd0, 32'h0,         32'h0,         32'h9,         32'h9};
    vecs[3] = '{4'h3, 5'd3, 5'd6, 32'h5,          32'h66,       32'h80,     32'hFFFFFFF0,  2'd1, 1'b1, 5'd4,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         32'h80,        32'hFFFFFFF0,  32'h66};
    vecs[4] = '{4'h4, 5'd7, 5'd6, 32'h1,          32'h2,        32'h0,      32'h0,         2'd0, 1'b0, 5'd5,  1'b1, 5'd7, 32'h700,       1'b1, 5'd6, 32'h600,       32'h700,       32'h600,       32'h600};
    vecs[5] = '{4'h5, 5'd3, 5'd4, 32'h5,          32'h7,        32'h44,     32'h0,         2'd2, 1'b0, 5'd6,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         32'h0,         32'h7,         32'h7};
    vecs[6] = '{4'h6, 5'd3, 5'd4, 32'h5,          32'h7,        32'h44,     32'h0,         2'd3, 1'b0, 5'd7,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         32'h0,         32'h7,         32'h7};
    vecs[7] = '{4'h7, 5'd3, 5'd4, 32'h55,         32'h77,       32'h0,      32'h0,         2'd0, 1'b0, 5'd8,  1'b0, 5'd3, 32'h111,       1'b1, 5'd4, 32'h444,       32'h55,        32'h444,       32'h444};
    vecs[8] = '{4'hF, 5'd9, 5'd0, 32'h900,        32'h99,       32'h0,      32'h0,         2'd0, 1'b0, 5'd31, 1'b1, 5'd9, 32'h9999,      1'b1, 5'd0, 32'hBEEF,      32'h9999,      32'h0,         32'h0};
    vecs[9] = '{4'hA, 5'd2, 5'd8, 32'h20,         32'h80,       32'h0,      32'h1234,      2'd0, 1'b1, 5'd12, 1'b1, 5'd8, 32'h888,       1'b1, 5'd2, 32'h222,       32'h222,       32'h1234,      32'h888};

    // ---- reset ----
    drive_idle();
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    rst_i       = 1'b1;
    step();
    step();
    check("rst_valid", 128'(out_valid_o), 128'(1'b0));
    check("rst_payload", 128'(cur_pkt()), 128'(0));
    rst_i = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready_o), 128'(1'b1));

    // ---- table: one instruction per cycle, downstream always ready ----
    out_ready_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d_in_ready", i), 128'(in_ready_o), 128'(1'b1));
      push_exp(vecs[i]);
      step();
      check_out($sformatf("vec%0d_out", i));
    end

    // ---- load-use hazard on rs2, output drains into a bubble ----
    va = vecs[0];
    va.op = 4'h8;
    va.rd = 5'd20;
    drive_vec(va);
    ex_load_i = 1'b1;
    ex_rd_i   = 5'd4;
    #1;
    check("hz_rs2_in_ready", 128'(in_ready_o), 128'(1'b0));
    step();
    check("hz_bubble_valid", 128'(out_valid_o), 128'(1'b0));
    ex_load_i = 1'b0;
    #1;
    check("hz_clear_in_ready", 128'(in_ready_o), 128'(1'b1));
    push_exp(va);
    step();
    check_out("hz_retry_out");

    // ---- hazard qualification (combinational only, not clocked) ----
    ex_load_i  = 1'b1;
    ex_rd_i    = 5'd3;
    in_rs1_i   = 5'd3;
    in_rs2_i   = 5'd4;
    in_a_sel_i = 2'd1;
    #1;
    check("hz_rs1_pcsel", 128'(in_ready_o), 128'(1'b1));
    in_a_sel_i = 2'd0;
    #1;
    check("hz_rs1_rs1sel", 128'(in_ready_o), 128'(1'b0));
    ex_rd_i  = 5'd0;
    in_rs1_i = 5'd0;
    in_rs2_i = 5'd0;
    #1;
    check("hz_x0", 128'(in_ready_o), 128'(1'b1));
    ex_load_i = 1'b0;
    ex_rd_i   = 5'd4;
    in_rs2_i  = 5'd4;
    #1;
    check("hz_no_load", 128'(in_ready_o), 128'(1'b1));
    drive_idle();
    step();
    check("drain_bubble", 128'(out_valid_o), 128'(1'b0));

    // ---- output stall for 3 cycles, then back-to-back ----
    va = '{4'h2, 5'd3, 5'd4, 32'h11, 32'h22, 32'h0, 32'h0, 2'd0, 1'b0, 5'd9,
           1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h22, 32'h22};
    vb = '{4'h3, 5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 32'h0, 2'd0, 1'b0, 5'd10,
           1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h33, 32'h44, 32'h44};
    vc = '{4'h9, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 32'h7, 2'd0, 1'b1, 5'd11,
           1'b1, 5'd5, 32'hAAAA, 1'b0, 5'd0, 32'h0, 32'hAAAA, 32'h7, 32'h2};
    drive_vec(va);
    push_exp(va);
    step();
    check_out("stall_load");
    out_ready_i = 1'b0;
    drive_vec(vb);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_in_ready", c), 128'(in_ready_o), 128'(1'b0));
      step();
      check($sformatf("stall%0d_valid", c), 128'(out_valid_o), 128'(1'b1));
      check($sformatf("stall%0d_hold", c), 128'(cur_pkt()),
            128'({va.op, va.exp_a, va.exp_b, va.exp_st, va.rd}));
    end
    out_ready_i = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready_o), 128'(1'b1));
    push_exp(vb);
    step();
    check_out("b2b_first");
    drive_vec(vc);
    push_exp(vc);
    step();
    check_out("b2b_second");

    // ---- flush with held valid and incoming valid ----
    vd = vecs[4];
    drive_vec(vd);
    out_ready_i = 1'b0;
    flush_i     = 1'b1;
    #1;
    check("flush_in_ready", 128'(in_ready_o), 128'(1'b0));
    step();
    check("flush_valid", 128'(out_valid_o), 128'(1'b0));
    flush_i = 1'b0;
    drive_idle();
    out_ready_i = 1'b1;
    step();
    check("flush_not_consumed", 128'(out_valid_o), 128'(1'b0));

    // ---- reset during a stall (flush also high: reset takes precedence) ----
    ve = vecs[9];
    drive_vec(ve);
    push_exp(ve);
    step();
    check_out("rst_stall_load");
    drive_idle();
    out_ready_i = 1'b0;
    step();
    check("rst_stall_held", 128'(out_valid_o), 128'(1'b1));
    rst_i   = 1'b1;
    flush_i = 1'b1;
    step();
    check("rst_stall_valid", 128'(out_valid_o), 128'(1'b0));
    check("rst_stall_payload", 128'(cur_pkt()), 128'(0));
    rst_i   = 1'b0;
    flush_i = 1'b0;
    step();
    check("post_rst_valid", 128'(out_valid_o), 128'(1'b0));

    check("exp_q_empty", 128'(exp_q.size()), 128'(0));

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
